// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: four-state issue controller feeding an external ALU from an 8x8 register file
module alu_issue_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid,
  input  logic [8:0] instr,
  output logic       instr_ready,
  input  logic       load_en,
  input  logic [2:0] load_reg,
  input  logic [7:0] load_data,
  output logic [7:0] alu_input_a,
  output logic [7:0] alu_input_b,
  output logic [2:0] alu_opcode,
  input  logic [7:0] alu_out,
  input  logic       zero,
  output logic       wb_valid,
  output logic [2:0] wb_reg,
  output logic [7:0] wb_data,
  output logic       zero_flag,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;
  state_t     r_state;
  logic [8:0] r_instr;
  logic [7:0] r_result;
  logic [7:0] r_rf [8];
  logic [2:0] w_op, w_rd, w_rb;
  assign w_op        = r_instr[8:6];
  assign w_rd        = r_instr[5:3];
  assign w_rb        = r_instr[2:0];
  assign instr_ready = (r_state == IDLE) && !load_en;
  assign busy        = r_state != IDLE;
  assign wb_data     = r_result;
  // sequencer: preload/accept in IDLE, operand fetch, result capture, writeback
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_instr     <= '0;
      r_result    <= '0;
      alu_input_a <= '0;
      alu_input_b <= '0;
      alu_opcode  <= '0;
      wb_valid    <= 1'b0;
      wb_reg      <= '0;
      zero_flag   <= 1'b0;
      for (int i = 0; i < 8; i++) r_rf[i] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (load_en) r_rf[load_reg] <= load_data;
          else if (instr_valid) begin
            r_instr <= instr;
            r_state <= READ;
          end
        end
        READ: begin
          alu_input_a <= r_rf[w_rd];
          alu_input_b <= r_rf[w_rb];
          alu_opcode  <= w_op;
          r_state     <= EXEC;
        end
        EXEC: begin
          r_result  <= alu_out;
          zero_flag <= zero;
          wb_valid  <= 1'b1;
          wb_reg    <= w_rd;
          r_state   <= WB;
        end
        default: begin
          r_rf[w_rd] <= r_result;
          wb_valid   <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: scoreboard bench for alu_issue_ctrl with a behavioural ALU
module tb_alu_issue_ctrl;
  logic       clk = 0, reset = 1, instr_valid = 0, load_en = 0, zero;
  logic [8:0] instr = '0;
  logic [2:0] load_reg = '0, alu_opcode, wb_reg;
  logic [7:0] load_data = '0, alu_input_a, alu_input_b, alu_out, wb_data;
  logic       instr_ready, wb_valid, zero_flag, busy;
  int         checks = 0, errors = 0;
  logic [7:0] m_rf [8];
  logic [10:0] q[$];

  alu_issue_ctrl dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .load_en(load_en), .load_reg(load_reg), .load_data(load_data),
    .alu_input_a(alu_input_a), .alu_input_b(alu_input_b), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .zero(zero), .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .zero_flag(zero_flag), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a + b;
      3'd2: return a - b;
      3'd3: return {7'd0, a < b};
      3'd4: return a | b;
      3'd5: return a ^ b;
      3'd6: return ~a;
      default: return b;
    endcase
  endfunction

  assign alu_out = alu_f(alu_opcode, alu_input_a, alu_input_b);
  assign zero    = alu_out == 8'h00;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [2:0] r, input logic [7:0] d);
    load_reg = r;
    load_data = d;
    load_en = 1;
    tick();
    load_en = 0;
    m_rf[r] = d;
  endtask

  task automatic accept(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rb);
    int n = 0;
    instr = {op, rd, rb};
    instr_valid = 1;
    #1;
    while (!instr_ready && n < 8) begin tick(); n++; end
    checks++;
    if (!instr_ready) begin errors++; $display("FAIL accept_timeout: instr_ready=%b required 1", instr_ready); end
    tick();
    instr_valid = 0;
    q.push_back({rd, alu_f(op, m_rf[rd], m_rf[rb])});
  endtask

  task automatic wait_wb(input string name);
    logic [10:0] e;
    int n = 0;
    while (!wb_valid && n < 8) begin tick(); n++; end
    checks++;
    if (!wb_valid || q.size() == 0) begin
      errors++;
      $display("FAIL %s wb: wb_valid=%b pending=%0d required wb_valid=1 with pending entry", name, wb_valid, q.size());
    end else begin
      e = q.pop_front();
      if ({wb_reg, wb_data} !== e || zero_flag !== (e[7:0] == 8'h00)) begin
        errors++;
        $display("FAIL %s wb: reg=%0d data=%h zero=%b required reg=%0d data=%h zero=%b",
                 name, wb_reg, wb_data, zero_flag, e[10:8], e[7:0], e[7:0] == 8'h00);
      end
      m_rf[e[10:8]] = e[7:0];
    end
  endtask

  task automatic test_reset();
    reset = 1;
    tick(); tick();
    reset = 0;
    foreach (m_rf[i]) m_rf[i] = 8'h00;
    checks++;
    if ({alu_input_a, alu_input_b, alu_opcode, wb_valid, wb_reg, wb_data, zero_flag, busy} !== '0 || instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: a=%h b=%h op=%0d wbv=%b wbr=%0d wbd=%h zf=%b busy=%b rdy=%b required all 0, rdy=1",
               alu_input_a, alu_input_b, alu_opcode, wb_valid, wb_reg, wb_data, zero_flag, busy, instr_ready);
    end
    accept(3'd4, 3'd7, 3'd0);
    tick();
    checks++;
    if (alu_input_a !== 8'h00 || alu_input_b !== 8'h00) begin
      errors++; $display("FAIL reset_rf: a=%h b=%h required 00 00", alu_input_a, alu_input_b);
    end
    wait_wb("reset_rf");
    tick();
  endtask

  task automatic test_add();
    preload(3'd1, 8'h05);
    preload(3'd2, 8'h03);
    accept(3'd1, 3'd1, 3'd2);
    checks++;
    if (busy !== 1'b1 || instr_ready !== 1'b0) begin
      errors++; $display("FAIL add_read: busy=%b rdy=%b required 1 0", busy, instr_ready);
    end
    tick();
    checks++;
    if (alu_input_a !== 8'h05 || alu_input_b !== 8'h03 || alu_opcode !== 3'd1 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL add_exec: a=%h b=%h op=%0d wbv=%b required 05 03 1 0", alu_input_a, alu_input_b, alu_opcode, wb_valid);
    end
    wait_wb("add");
    checks++;
    if (wb_reg !== 3'd1 || wb_data !== 8'h08 || zero_flag !== 1'b0) begin
      errors++; $display("FAIL add_const: reg=%0d data=%h zf=%b required 1 08 0", wb_reg, wb_data, zero_flag);
    end
    tick();
    checks++;
    if (wb_valid !== 1'b0 || wb_data !== 8'h08 || instr_ready !== 1'b1) begin
      errors++; $display("FAIL add_after: wbv=%b data=%h rdy=%b required 0 08 1", wb_valid, wb_data, instr_ready);
    end
  endtask

  task automatic test_sub_zero();
    preload(3'd3, 8'hAA);
    accept(3'd2, 3'd3, 3'd3);
    tick();
    checks++;
    if (alu_input_a !== 8'hAA || alu_input_b !== 8'hAA) begin
      errors++; $display("FAIL same_reg: a=%h b=%h required AA AA", alu_input_a, alu_input_b);
    end
    wait_wb("sub_zero");
    checks++;
    if (wb_data !== 8'h00 || zero_flag !== 1'b1) begin
      errors++; $display("FAIL sub_zero_const: data=%h zf=%b required 00 1", wb_data, zero_flag);
    end
    tick();
    accept(3'd1, 3'd3, 3'd3);
    tick();
    checks++;
    if (alu_input_a !== 8'h00) begin
      errors++; $display("FAIL sub_zero_rf: a=%h required 00", alu_input_a);
    end
    wait_wb("sub_zero_rd");
    tick();
  endtask

  task automatic test_back_to_back();
    int wbc[$];
    int lows = 0, acc = 0;
    logic [10:0] e;
    preload(3'd1, 8'h01);
    preload(3'd2, 8'h01);
    q.push_back({3'd1, 8'h02});
    q.push_back({3'd1, 8'h03});
    instr = {3'b001, 3'd1, 3'd2};
    instr_valid = 1;
    #1;
    for (int c = 0; c < 9; c++) begin
      if (!instr_ready) lows++;
      if (instr_ready && instr_valid) acc++;
      if (wb_valid) begin
        wbc.push_back(c);
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL b2b_extra_wb: cycle=%0d data=%h required no writeback", c, wb_data);
        end else begin
          e = q.pop_front();
          if ({wb_reg, wb_data} !== e) begin
            errors++; $display("FAIL b2b_wb: reg=%0d data=%h required reg=%0d data=%h", wb_reg, wb_data, e[10:8], e[7:0]);
          end
        end
      end
      if (c < 8) begin
        tick();
        if (acc == 2) instr_valid = 0;
      end
    end
    m_rf[1] = 8'h03;
    checks++;
    if (wbc.size() != 2 || lows != 6) begin
      errors++; $display("FAIL b2b_timing: wb_count=%0d ready_low=%0d required 2 6", wbc.size(), lows);
    end else if (wbc[0] != 3 || wbc[1] != 7) begin
      errors++; $display("FAIL b2b_timing: wb cycles %0d,%0d required 3,7", wbc[0], wbc[1]);
    end
  endtask

  task automatic test_load_conflict();
    preload(3'd5, 8'h3C);
    load_en = 1; load_reg = 3'd4; load_data = 8'h21;
    instr = {3'b001, 3'd4, 3'd4}; instr_valid = 1;
    #1;
    checks++;
    if (instr_ready !== 1'b0) begin errors++; $display("FAIL conflict_ready: rdy=%b required 0", instr_ready); end
    tick();
    m_rf[4] = 8'h21;
    load_en = 0;
    #1;
    checks++;
    if (busy !== 1'b0 || instr_ready !== 1'b1) begin
      errors++; $display("FAIL conflict_noaccept: busy=%b rdy=%b required 0 1", busy, instr_ready);
    end
    tick();
    instr_valid = 0;
    q.push_back({3'd4, 8'h42});
    tick();
    checks++;
    if (alu_input_a !== 8'h21) begin errors++; $display("FAIL conflict_preload: a=%h required 21", alu_input_a); end
    load_en = 1; load_reg = 3'd5; load_data = 8'hFF;
    tick();
    load_en = 0;
    wait_wb("conflict");
    tick();
    accept(3'd1, 3'd4, 3'd5);
    tick();
    checks++;
    if (alu_input_a !== 8'h42 || alu_input_b !== 8'h3C) begin
      errors++; $display("FAIL busy_load_ignored: a=%h b=%h required 42 3C", alu_input_a, alu_input_b);
    end
    wait_wb("busy_load");
    tick();
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    preload(3'd6, 8'h11);
    accept(3'd1, 3'd6, 3'd6);
    tick();
    load_en = 1; instr_valid = 1; reset = 1;
    tick();
    reset = 0; load_en = 0; instr_valid = 0;
    q.delete();
    foreach (m_rf[i]) m_rf[i] = 8'h00;
    #1;
    checks++;
    if ({alu_input_a, alu_input_b, alu_opcode, wb_valid, wb_reg, wb_data, zero_flag, busy} !== '0 || instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: a=%h b=%h op=%0d wbv=%b wbr=%0d wbd=%h zf=%b busy=%b rdy=%b required all 0, rdy=1",
               alu_input_a, alu_input_b, alu_opcode, wb_valid, wb_reg, wb_data, zero_flag, busy, instr_ready);
    end
    for (int c = 0; c < 4; c++) begin
      if (wb_valid) pulses++;
      tick();
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL mid_reset_wb: pulses=%0d required 0", pulses); end
    accept(3'd1, 3'd6, 3'd6);
    tick();
    checks++;
    if (alu_input_a !== 8'h00) begin errors++; $display("FAIL mid_reset_rf: a=%h required 00", alu_input_a); end
    wait_wb("mid_reset");
    tick();
  endtask

  task automatic test_slt();
    preload(3'd4, 8'h02);
    preload(3'd5, 8'h07);
    accept(3'd3, 3'd4, 3'd5);
    wait_wb("slt_lt");
    checks++;
    if (wb_data !== 8'h01 || zero_flag !== 1'b0) begin
      errors++; $display("FAIL slt_lt_const: data=%h zf=%b required 01 0", wb_data, zero_flag);
    end
    tick();
    preload(3'd4, 8'h07);
    preload(3'd5, 8'h02);
    accept(3'd3, 3'd4, 3'd5);
    wait_wb("slt_ge");
    checks++;
    if (wb_data !== 8'h00 || zero_flag !== 1'b1) begin
      errors++; $display("FAIL slt_ge_const: data=%h zf=%b required 00 1", wb_data, zero_flag);
    end
    tick();
  endtask

  task automatic test_all_ops();
    logic [2:0] rb;
    for (int op = 0; op < 8; op++) begin
      rb = 3'(7 - op);
      preload(3'(op), 8'($urandom_range(0, 255)));
      preload(rb, 8'($urandom_range(0, 255)));
      accept(3'(op), 3'(op), rb);
      tick();
      checks++;
      if (alu_opcode !== 3'(op) || alu_input_a !== m_rf[op] || alu_input_b !== m_rf[rb]) begin
        errors++;
        $display("FAIL op%0d_exec: op=%0d a=%h b=%h required %0d %h %h", op, alu_opcode, alu_input_a, alu_input_b, op, m_rf[op], m_rf[rb]);
      end
      wait_wb("all_ops");
      tick();
    end
    accept(3'd7, 3'd1, 3'd0);
    tick();
    checks++;
    if (alu_input_b !== m_rf[0]) begin errors++; $display("FAIL rf0_write: b=%h required %h", alu_input_b, m_rf[0]); end
    wait_wb("rf0");
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_zero();
    test_back_to_back();
    test_load_conflict();
    test_reset_mid();
    test_slt();
    test_all_ops();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Ports SHALL be: clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 instr_valid  in  1  instruction offered.
REQ-004 instr  in  9  [8:6] ALU opcode, [5:3] rd (also operand A), [2:0] rb (operand B).
REQ-005 instr_ready  out  1  block can accept an instruction this cycle.
REQ-006 load_en  in  1  register preload strobe.
REQ-007 load_reg  in  3  preload target register.
REQ-008 load_data  in  8  preload value.
REQ-009 alu_input_a  out  8  registered operand A to ALU.
REQ-010 alu_input_b  out  8  registered operand B to ALU.
REQ-011 alu_opcode  out  3  registered opcode to ALU.
REQ-012 alu_out  in  8  combinational ALU result.
REQ-013 zero  in  1  combinational ALU zero flag.
REQ-014 wb_valid  out  1  one-cycle pulse: writeback occurring.
REQ-015 wb_reg  out  3  destination register of writeback.
REQ-016 wb_data  out  8  writeback value.
REQ-017 zero_flag  out  1  zero flag of last completed instruction.
REQ-018 busy  out  1  high whenever state is not IDLE.

Function
REQ-019 Block SHALL hold an internal 8-entry x 8-bit register file rf[0..7]; all entries writable, including rf[0].
REQ-020 FSM states SHALL be IDLE, READ, EXEC, WB; transitions IDLE->READ on accept, READ->EXEC, EXEC->WB, WB->IDLE unconditionally.
REQ-021 instr_ready SHALL equal (state==IDLE) && !load_en.
REQ-022 Accept SHALL occur on an edge where instr_valid && instr_ready; instr is latched into an internal instruction register at that edge.
REQ-023 Preload SHALL occur only on an edge in IDLE with load_en=1: rf[load_reg] <= load_data; load_en outside IDLE SHALL be ignored.
REQ-024 load_en and instr_valid together in IDLE: preload performed, instruction not accepted (instr_ready=0).
REQ-025 READ->EXEC edge SHALL load alu_input_a <= rf[rd], alu_input_b <= rf[rb], alu_opcode <= opcode.
REQ-026 EXEC->WB edge SHALL capture alu_out into result register and zero into zero_flag.
REQ-027 During WB: wb_valid=1, wb_reg=rd, wb_data=result register; at WB->IDLE edge rf[rd] <= result.
REQ-028 wb_valid SHALL be 0 in every non-WB state; wb_reg/wb_data hold last values outside WB.
REQ-029 Latency: accept at edge E0 -> wb_valid high in the cycle after E2 -> rf updated at E3; instr_ready high again in the cycle after E3 (one instruction per 4 cycles).
REQ-030 rd==rb SHALL read the same pre-instruction value for both operands.
REQ-031 Back-to-back dependent instructions SHALL see the previous result (writeback completes before next READ).
REQ-032 alu_input_a/b/alu_opcode SHALL hold their values in all states other than the READ->EXEC update.
REQ-033 All eight opcodes SHALL be issued and written back identically; block does not interpret opcode.

Reset
REQ-034 reset=1 at an edge SHALL force state IDLE, rf all 0x00, alu_input_a/b=0x00, alu_opcode=3'b000, wb_valid=0, wb_reg=0, wb_data=0x00, zero_flag=0, busy=0.
REQ-035 reset asserted mid-instruction SHALL abandon it: no wb_valid pulse, no rf write; reset overrides load_en and instr_valid.
REQ-036 instr_ready SHALL be 1 in the first cycle after reset deasserts (load_en=0).

Verification
REQ-037 Preload rf[1]=0x05, rf[2]=0x03; issue opcode 001 rd=1 rb=2 -> alu_input_a=0x05, alu_input_b=0x03 in EXEC; wb_valid pulse with wb_reg=1, wb_data=0x08; zero_flag=0.
REQ-038 Preload rf[3]=0xAA; issue opcode 010 rd=3 rb=3 -> wb_data=0x00, zero_flag=1, rf[3]=0x00 afterwards.
REQ-039 Hold instr_valid=1 continuously with two instructions (ADD r1,r2 then ADD r1,r2, r1=0x01, r2=0x01) -> wb_data 0x02 then 0x03, exactly 4 cycles apart; instr_ready low for 3 cycles after each accept.
REQ-040 Assert load_en and instr_valid together in IDLE -> preload applied, instruction not accepted until load_en drops; load_en during EXEC -> rf unchanged.
REQ-041 Assert reset during EXEC -> no wb_valid, all outputs and rf zero, instr_ready=1 next cycle.
REQ-042 Opcode 011 rd=4 (0x02) rb=5 (0x07) -> wb_data=0x01; swap values -> wb_data=0x00, zero_flag=1.
